ebus_ctl: RTL and testbench

EBUS owner and I/O cycle sequencer for the KL10 EBUS. Arbitrates the five EBOX-internal EBUS drivers (EDP, IR, SCD, APR, CRA) into one registered EBUS and runs demand/transfer handshake cycles to external EBUS devices (RH20, DTE20) on EBOX request. Lives at top level beside ebox, replacing the bare priority mux, because external controllers also hang off EBUS.

---
 rtl/ebus_ctl.sv | 170 +++++++++++++++++
 tb/tb_ebus_ctl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_ctl.sv
// EBUS owner: registered priority mux of the five EBOX drivers plus the external I/O demand/transfer sequencer.
// Optional macro EBUS_CONFLICT_CHECK_EN builds the multi-driver conflict detector; otherwise ebusConflict is tied low.
module ebus_ctl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [0:4]   drivingEBUS,
  input  logic [0:179] drvEBUS,
  output logic [0:35]  EBUS,
  output logic         ebusConflict,
  input  logic         ioReq,
  input  logic         ioWrite,
  input  logic [0:7]   ioDS,
  input  logic [0:35]  ioData,
  output logic         ioBusy,
  output logic         ioDone,
  output logic         ioTimeout,
  output logic [0:35]  ioRdData,
  output logic [0:7]   EBUS_DS,
  output logic         ebusDemand,
  input  logic         ebusXfer,
  input  logic [0:35]  devEBUS
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, DEMAND, RELEASE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        tmo_flag;
  logic        wr_lat;
  logic [0:7]  ds_reg;
  logic [0:35] wdata_lat;
  logic [0:35] rd_data;
  logic [0:35] bus, bus_nxt;
  logic        accept, capture, abort, expired;

  assign expired = (cnt == TMO_LIMIT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ioReq) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = DEMAND;
      DEMAND: begin
        // An acknowledge wins over expiry when both land in the same cycle.
        if (ebusXfer) begin
          capture   = 1'b1;
          state_nxt = RELEASE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      RELEASE: begin
        if (!ebusXfer) begin
          state_nxt = DONE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus source priority: I/O write or read capture, then EDP > IR > SCD > APR > CRA, else hold.
  always_comb begin
    bus_nxt = bus;
    if ((state == SETUP || state == DEMAND) && wr_lat)
      bus_nxt = wdata_lat;
    else if (capture && !wr_lat)
      bus_nxt = devEBUS;
    else if (drivingEBUS[0])
      bus_nxt = drvEBUS[0:35];
    else if (drivingEBUS[1])
      bus_nxt = drvEBUS[36:71];
    else if (drivingEBUS[2])
      bus_nxt = drvEBUS[72:107];
    else if (drivingEBUS[3])
      bus_nxt = drvEBUS[108:143];
    else if (drivingEBUS[4])
      bus_nxt = drvEBUS[144:179];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      // Counter restarts at 1 on entry to DEMAND or RELEASE so it equals the cycle number within the phase.
      if (state_nxt == DEMAND || state_nxt == RELEASE)
        cnt <= (state_nxt != state) ? 8'd1 : cnt + 8'd1;
      else
        cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      tmo_flag  <= 1'b0;
      wr_lat    <= 1'b0;
      wdata_lat <= '0;
      ds_reg    <= '0;
      rd_data   <= '0;
      bus       <= '0;
    end else begin
      bus <= bus_nxt;
      if (accept) begin
        tmo_flag  <= 1'b0;
        wr_lat    <= ioWrite;
        wdata_lat <= ioData;
        ds_reg    <= ioDS;
        rd_data   <= '0;
      end else begin
        if (abort)
          tmo_flag <= 1'b1;
        if (capture && !wr_lat)
          rd_data <= devEBUS;
        else if (abort && !wr_lat)
          rd_data <= '0;
        if (state == DONE)
          ds_reg <= '0;
      end
    end
  end

  assign EBUS       = bus;
  assign EBUS_DS    = ds_reg;
  assign ioRdData   = rd_data;
  assign ioBusy     = (state != IDLE);
  assign ioDone     = (state == DONE);
  assign ioTimeout  = (state == DONE) && tmo_flag;
  assign ebusDemand = (state == DEMAND);

`ifdef EBUS_CONFLICT_CHECK_EN
  logic [2:0] drv_count;
  logic       conflict;

  always_comb begin
    drv_count = 3'd0;
    for (int i = 0; i < 5; i++)
      drv_count = drv_count + {2'b00, drivingEBUS[i]};
  end

  always_ff @(posedge clk) begin
    if (!resetN)
      conflict <= 1'b0;
    else
      conflict <= (drv_count > 3'd1);
  end

  assign ebusConflict = conflict;
`else
  assign ebusConflict = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_ctl.sv
// Directed scoreboard bench for ebus_ctl: default-timeout instance plus a TIMEOUT_CYCLES=4 instance on shared inputs.
module tb_ebus_ctl;

  logic         clk = 1'b0;
  logic         resetN;
  logic [0:4]   drivingEBUS;
  logic [0:179] drvEBUS;
  logic         ioReq, ioWrite, ebusXfer;
  logic [0:7]   ioDS;
  logic [0:35]  ioData, devEBUS;

  logic [0:35] a_ebus, a_rd, b_ebus, b_rd;
  logic [0:7]  a_ds, b_ds;
  logic        a_conf, a_busy, a_done, a_tmo, a_dem;
  logic        b_conf, b_busy, b_done, b_tmo, b_dem;

`ifdef EBUS_CONFLICT_CHECK_EN
  localparam logic CONF_ON = 1'b1;
`else
  localparam logic CONF_ON = 1'b0;
`endif

  ebus_ctl dut (
    .clk(clk), .resetN(resetN), .drivingEBUS(drivingEBUS), .drvEBUS(drvEBUS),
    .EBUS(a_ebus), .ebusConflict(a_conf), .ioReq(ioReq), .ioWrite(ioWrite),
    .ioDS(ioDS), .ioData(ioData), .ioBusy(a_busy), .ioDone(a_done),
    .ioTimeout(a_tmo), .ioRdData(a_rd), .EBUS_DS(a_ds), .ebusDemand(a_dem),
    .ebusXfer(ebusXfer), .devEBUS(devEBUS)
  );

  ebus_ctl #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .resetN(resetN), .drivingEBUS(drivingEBUS), .drvEBUS(drvEBUS),
    .EBUS(b_ebus), .ebusConflict(b_conf), .ioReq(ioReq), .ioWrite(ioWrite),
    .ioDS(ioDS), .ioData(ioData), .ioBusy(b_busy), .ioDone(b_done),
    .ioTimeout(b_tmo), .ioRdData(b_rd), .EBUS_DS(b_ds), .ebusDemand(b_dem),
    .ebusXfer(ebusXfer), .devEBUS(devEBUS)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sb_q[$];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; drivingEBUS = '0; drvEBUS = '0; ioReq = 1'b0; ioWrite = 1'b0;
    ioDS = '0; ioData = '0; ebusXfer = 1'b0; devEBUS = '0;
    tick(2);

    // Reset state
    want(0); want(0); want(0); want(0); want(0); want(0); want(0); want(0);
    check("rst_ebus", 64'(a_ebus)); check("rst_ds", 64'(a_ds));
    check("rst_demand", 64'(a_dem)); check("rst_busy", 64'(a_busy));
    check("rst_done", 64'(a_done)); check("rst_timeout", 64'(a_tmo));
    check("rst_rddata", 64'(a_rd)); check("rst_conflict", 64'(a_conf));
    resetN = 1'b1;
    tick();

    // EDP and SCD together: EDP wins, conflict pulses once
    drvEBUS[0:35]    = 36'o111111111111;
    drvEBUS[36:71]   = 36'o333333333333;
    drvEBUS[72:107]  = 36'o222222222222;
    drvEBUS[108:143] = 36'o444444444444;
    drvEBUS[144:179] = 36'o555555555555;
    drivingEBUS = 5'b10100;
    want(36'o111111111111); want(64'(CONF_ON));
    tick();
    check("edp_scd_ebus", 64'(a_ebus)); check("edp_scd_conflict", 64'(a_conf));
    drivingEBUS = 5'b00000;
    want(36'o111111111111); want(0);
    tick();
    check("idle_hold_ebus", 64'(a_ebus)); check("conflict_single_pulse", 64'(a_conf));

    // APR over CRA
    drivingEBUS = 5'b00011;
    want(36'o444444444444); want(64'(CONF_ON));
    tick();
    check("apr_cra_ebus", 64'(a_ebus)); check("apr_cra_conflict", 64'(a_conf));

    // IR drives 777, then bus holds while idle
    drvEBUS[36:71] = 36'o777;
    drivingEBUS = 5'b01000;
    want(36'o777);
    tick();
    check("ir_ebus", 64'(a_ebus));
    drivingEBUS = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      want(36'o777);
      tick(2);
      check("ir_hold_ebus", 64'(a_ebus));
    end

    // Write cycle: ack on first DEMAND cycle, dropped one cycle later
    ioReq = 1'b1; ioWrite = 1'b1; ioDS = 8'h5A; ioData = 36'o123456701234;
    want(1); want(8'h5A); want(0); want(0);
    tick();
    check("wr_setup_busy", 64'(a_busy)); check("wr_setup_ds", 64'(a_ds));
    check("wr_setup_demand", 64'(a_dem)); check("wr_setup_done", 64'(a_done));
    ioReq = 1'b0; ebusXfer = 1'b1;
    drivingEBUS = 5'b10000;
    want(1); want(36'o123456701234); want(8'h5A);
    tick();
    check("wr_demand", 64'(a_dem)); check("wr_demand_ebus", 64'(a_ebus));
    check("wr_demand_ds", 64'(a_ds));
    drivingEBUS = 5'b00000;
    want(0); want(1); want(36'o123456701234);
    tick();
    check("wr_release_demand", 64'(a_dem)); check("wr_release_busy", 64'(a_busy));
    check("wr_release_ebus", 64'(a_ebus));
    ebusXfer = 1'b0;
    want(1); want(0); want(1); want(8'h5A);
    tick();
    check("wr_done", 64'(a_done)); check("wr_done_timeout", 64'(a_tmo));
    check("wr_done_busy", 64'(a_busy)); check("wr_done_ds", 64'(a_ds));
    want(0); want(0); want(0);
    tick();
    check("wr_after_done", 64'(a_done)); check("wr_after_busy", 64'(a_busy));
    check("wr_after_ds", 64'(a_ds));

    // Read cycle: ack in the 10th DEMAND cycle
    ioReq = 1'b1; ioWrite = 1'b0; ioDS = 8'h33; devEBUS = 36'o765432107654;
    tick();
    ioReq = 1'b0;
    tick();
    want(1);
    check("rd_demand_start", 64'(a_dem));
    tick(9);
    want(1); want(0);
    check("rd_demand_10th", 64'(a_dem)); check("rd_no_early_done", 64'(a_done));
    ebusXfer = 1'b1;
    want(36'o765432107654); want(36'o765432107654);
    tick();
    check("rd_capture_rddata", 64'(a_rd)); check("rd_capture_ebus", 64'(a_ebus));
    ebusXfer = 1'b0;
    want(1); want(0); want(36'o765432107654);
    tick();
    check("rd_done", 64'(a_done)); check("rd_done_timeout", 64'(a_tmo));
    check("rd_done_rddata", 64'(a_rd));
    tick();

    // Timeout on the 4-cycle instance, after a good read leaves nonzero read data
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    ioReq = 1'b1; ioWrite = 1'b0; ioDS = 8'h11; devEBUS = 36'o707070707070;
    tick();
    ioReq = 1'b0; ebusXfer = 1'b1;
    tick(2);
    ebusXfer = 1'b0;
    want(1); want(36'o707070707070);
    tick();
    check("t4_good_done", 64'(b_done)); check("t4_good_rddata", 64'(b_rd));
    tick();
    ioReq = 1'b1; ioDS = 8'h22;
    tick();
    ioReq = 1'b0;
    tick();
    want(1);
    check("t4_demand_c1", 64'(b_dem));
    tick(3);
    want(1); want(0);
    check("t4_demand_c4", 64'(b_dem)); check("t4_c4_done", 64'(b_done));
    want(0); want(1); want(1); want(0);
    tick();
    check("t4_demand_dropped", 64'(b_dem)); check("t4_done", 64'(b_done));
    check("t4_timeout", 64'(b_tmo)); check("t4_rddata_zero", 64'(b_rd));
    tick();

    // Reset during DEMAND, then a fresh write completes
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    drivingEBUS = 5'b00100;
    tick();
    drivingEBUS = 5'b00000;
    ioReq = 1'b1; ioWrite = 1'b1; ioDS = 8'hC3; ioData = 36'o246024602460;
    tick();
    ioReq = 1'b0;
    tick();
    want(1);
    check("mid_demand_before_reset", 64'(a_dem));
    resetN = 1'b0;
    want(0); want(0); want(0); want(0); want(0);
    tick();
    check("mid_reset_demand", 64'(a_dem)); check("mid_reset_busy", 64'(a_busy));
    check("mid_reset_ebus", 64'(a_ebus)); check("mid_reset_done", 64'(a_done));
    check("mid_reset_ds", 64'(a_ds));
    resetN = 1'b1;
    want(0);
    tick();
    check("mid_reset_no_done", 64'(a_done));
    ioReq = 1'b1; ioWrite = 1'b1; ioDS = 8'h0F; ioData = 36'o135713571357;
    tick();
    ioReq = 1'b0; ebusXfer = 1'b1;
    tick(2);
    ebusXfer = 1'b0;
    want(1); want(0); want(36'o135713571357); want(8'h0F);
    tick();
    check("fresh_done", 64'(a_done)); check("fresh_timeout", 64'(a_tmo));
    check("fresh_ebus", 64'(a_ebus)); check("fresh_ds", 64'(a_ds));
    tick();

    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
